// File: rtl/capture_ctrl.sv
// Trace capture sequencer: fills a 512-entry circular sample RAM, arms, waits for trigger, captures post-trigger samples.
// Optional decimation is compiled in with `define CAPTURE_DECIM_EN; otherwise a sample is taken every clock.
module capture_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trigger,
  input  logic       capture_done,
  input  logic [8:0] trig_pos,
  input  logic [3:0] decimator,
  output logic       armed,
  output logic       set_capture_done,
  output logic       we,
  output logic [8:0] waddr,
  output logic [8:0] trace_end
);

  localparam int unsigned AW = 9;
  localparam int unsigned CW = 10;
  localparam int unsigned DW = 4;

  typedef enum logic [2:0] {IDLE, FILL, ARMED, POST, DONE} state_t;

  state_t        state, state_next;
  logic [CW-1:0] fill_cnt, fill_cnt_next, fill_inc, fill_thresh;
  logic [CW-1:0] dec_cnt, dec_cnt_next, dec_mask;
  logic [AW-1:0] post_cnt, post_cnt_next;
  logic [AW-1:0] waddr_next, trace_end_next;
  logic          armed_next, scd_next, we_next, active_next;

  // Tick period mask: 2^decimator-1, saturated at the largest legal exponent
`ifdef CAPTURE_DECIM_EN
  logic [DW-1:0] decim_sat;
  assign decim_sat = (decimator > DW'(9)) ? DW'(9) : decimator;
  assign dec_mask  = (CW'(1) << decim_sat) - CW'(1);
`else
  logic unused_decimator;
  assign unused_decimator = ^decimator;
  assign dec_mask         = '0;
`endif

  assign fill_inc    = fill_cnt + CW'(1);
  assign fill_thresh = CW'(512) - CW'(trig_pos);

  // we is registered one cycle ahead so that it coincides with the sample tick
  always_comb begin
    state_next     = state;
    fill_cnt_next  = fill_cnt;
    dec_cnt_next   = '0;
    post_cnt_next  = post_cnt;
    waddr_next     = we ? (waddr + AW'(1)) : waddr;
    trace_end_next = trace_end;

    case (state)
      IDLE: begin
        fill_cnt_next = '0;
        if (!capture_done) state_next = FILL;
      end
      FILL: begin
        dec_cnt_next = we ? '0 : (dec_cnt + CW'(1));
        if (we) begin
          fill_cnt_next = fill_inc;
          if (fill_inc == fill_thresh) state_next = ARMED;
        end
      end
      ARMED: begin
        dec_cnt_next = we ? '0 : (dec_cnt + CW'(1));
        if (trigger) begin
          if (trig_pos == '0) begin
            state_next = DONE;
          end else begin
            state_next    = POST;
            post_cnt_next = trig_pos;
          end
        end
      end
      POST: begin
        dec_cnt_next = we ? '0 : (dec_cnt + CW'(1));
        if (we) begin
          post_cnt_next = post_cnt - AW'(1);
          if (post_cnt <= AW'(1)) state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // DONE never repeats, so entering it is the single completion event
    if (state_next == DONE) trace_end_next = waddr_next - AW'(1);

    active_next = (state_next == FILL) || (state_next == ARMED) || (state_next == POST);
    armed_next  = (state_next == ARMED) || (state_next == POST);
    scd_next    = (state_next == DONE);
    we_next     = active_next && (dec_cnt_next == dec_mask);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      fill_cnt         <= '0;
      dec_cnt          <= '0;
      post_cnt         <= '0;
      waddr            <= '0;
      trace_end        <= '0;
      armed            <= 1'b0;
      set_capture_done <= 1'b0;
      we               <= 1'b0;
    end else begin
      state            <= state_next;
      fill_cnt         <= fill_cnt_next;
      dec_cnt          <= dec_cnt_next;
      post_cnt         <= post_cnt_next;
      waddr            <= waddr_next;
      trace_end        <= trace_end_next;
      armed            <= armed_next;
      set_capture_done <= scd_next;
      we               <= we_next;
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// Randomized directed bench for capture_ctrl against a per-phase behavioural model of the capture rules.
// Works with or without CAPTURE_DECIM_EN defined.
module tb_capture_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       trigger = 1'b0;
  logic       capture_done = 1'b1;
  logic [8:0] trig_pos = '0;
  logic [3:0] decimator = '0;
  logic       armed, set_capture_done, we;
  logic [8:0] waddr, trace_end;

  int checks = 0;
  int errors = 0;

  // Model: phase 0 idle, 1 fill, 2 armed, 3 post, 4 done
  int m_phase, m_age, m_writes, m_post, m_waddr, m_trace_end;

  capture_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .trigger          (trigger),
    .capture_done     (capture_done),
    .trig_pos         (trig_pos),
    .decimator        (decimator),
    .armed            (armed),
    .set_capture_done (set_capture_done),
    .we               (we),
    .waddr            (waddr),
    .trace_end        (trace_end)
  );

  always #5 clk = ~clk;

  function automatic int period();
`ifdef CAPTURE_DECIM_EN
    return 1 << decimator;
`else
    return 1;
`endif
  endfunction

  // Samples fall every period() clocks counted from the first FILL cycle
  function automatic bit m_we();
    return (m_phase >= 1 && m_phase <= 3) && (((m_age + 1) % period()) == 0);
  endfunction

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("armed", 10'(armed), 10'(m_phase == 2 || m_phase == 3));
    chk("set_capture_done", 10'(set_capture_done), 10'(m_phase == 4));
    chk("we", 10'(we), 10'(m_we()));
    chk("waddr", 10'(waddr), 10'(m_waddr));
    chk("trace_end", 10'(trace_end), 10'(m_trace_end));
  endtask

  task automatic model_reset();
    m_phase = 0; m_age = 0; m_writes = 0; m_post = 0; m_waddr = 0; m_trace_end = 0;
  endtask

  task automatic model_update();
    bit w;
    w = m_we();
    if (w) m_waddr = (m_waddr + 1) % 512;
    case (m_phase)
      0: if (!capture_done) begin m_phase = 1; m_age = 0; m_writes = 0; end
      1: begin
        if (w) begin
          m_writes++;
          if (m_writes == 512 - int'(trig_pos)) m_phase = 2;
        end
        m_age++;
      end
      2: begin
        m_age++;
        if (trigger) begin
          if (trig_pos == 0) begin m_phase = 4; m_trace_end = (m_waddr + 511) % 512; end
          else begin m_phase = 3; m_post = int'(trig_pos); end
        end
      end
      3: begin
        m_age++;
        if (w) begin
          m_post--;
          if (m_post == 0) begin m_phase = 4; m_trace_end = (m_waddr + 511) % 512; end
        end
      end
      default: m_phase = 0;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_update();
    @(negedge clk);
    check_all();
  endtask

  // Assert reset mid-cycle; outputs must clear without waiting for a clock edge
  task automatic do_reset(input bit trig_level);
    #2;
    rst_n = 1'b0;
    trigger = trig_level;
    capture_done = 1'b1;
    #1;
    model_reset();
    check_all();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic run_capture(input int trig_at, input bit abort);
    int n_we = 0;
    int n_scd = 0;
    int pre = -1;
    int first_we = -1;
    int gap = -1;
    bit ended = 0;
    capture_done = 1'b0;
    trigger = (trig_at == 0);
    for (int c = 0; c < 30000 && !ended; c++) begin
      tick();
      if (armed && pre < 0) pre = n_we;
      if (we) begin
        if (first_we < 0) first_we = c;
        else if (gap < 0) gap = c - first_we;
        n_we++;
      end
      if (abort && m_phase == 3 && m_post < int'(trig_pos)) begin
        do_reset(1'b0);
        for (int k = 0; k < 3; k++) begin
          tick();
          if (set_capture_done) n_scd++;
        end
        chk("abort_no_pulse", 10'(n_scd), 10'd0);
        return;
      end
      if (c + 1 >= trig_at) trigger = 1'b1;
      if (set_capture_done) begin
        n_scd++;
        ended = 1;
        capture_done = 1'b1;
        trigger = 1'b0;
      end
    end
    chk("capture_end", 10'(ended), 10'd1);
    chk("pre_trigger_writes", 10'(pre), 10'(512 - int'(trig_pos)));
    chk("we_spacing", 10'(gap), 10'(period()));
    for (int k = 0; k < 3; k++) begin
      tick();
      if (set_capture_done) n_scd++;
    end
    chk("done_pulses", 10'(n_scd), 10'd1);
  endtask

  initial begin
    model_reset();
    do_reset(1'b0);
    for (int k = 0; k < 5; k++) tick();

    // Baseline: no decimation, trigger well after arming
    decimator = 4'd0;
    trig_pos = 9'd100;
    run_capture(600, 0);

    // Host has not read the trace yet: stay idle, then resume from the old waddr
    for (int k = 0; k < 10; k++) tick();
    decimator = 4'd2;
    trig_pos = 9'($urandom_range(1, 511));
    run_capture(int'($urandom_range(0, 3000)), 0);

    // No post-trigger samples
    decimator = 4'd1;
    trig_pos = 9'd0;
    run_capture(300, 0);

    // Trigger held through reset: ignored until armed
    do_reset(1'b1);
    decimator = 4'd0;
    trig_pos = 9'd256;
    run_capture(0, 0);

    // Reset asserted in the middle of POST
    decimator = 4'd1;
    trig_pos = 9'd300;
    run_capture(50, 1);
    for (int k = 0; k < 3; k++) tick();

    for (int n = 0; n < 4; n++) begin
      decimator = 4'($urandom_range(0, 2));
      trig_pos = 9'($urandom_range(0, 511));
      run_capture(int'($urandom_range(0, 700 * period())), 0);
      for (int k = 0; k < int'($urandom_range(0, 4)); k++) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
